// File: rtl/writeback_scoreboard.sv
// Write side of the 4-lane VLIW register file. It counts pending writes per
// destination register to raise the D-stage hazard stall, and registers lane results into the rf write ports.
module writeback_scoreboard #(
   parameter int unsigned NREG  = 64,
   parameter int unsigned CNT_W = 2,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              issue_valid,
   input  logic [3:0]        issue_we,
   input  logic [4*AW-1:0]   issue_dst,
   input  logic [8*AW-1:0]   issue_src,
   input  logic [7:0]        issue_srcv,
   output logic              hazard_existenceD,
   output logic              issue_accept,
   input  logic [3:0]        wb_we,
   input  logic [4*AW-1:0]   wb_dst,
   input  logic [127:0]      wb_data,
   output logic [3:0]        rf_we,
   output logic [4*AW-1:0]   rf_wr_addr,
   output logic [127:0]      rf_wr_data,
   output logic              sb_err
);

   localparam int unsigned   CW   = CNT_W + 2;
   localparam logic [CW-1:0] CMAX = CW'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [CW-1:0]    inc   [NREG];
   logic [CW-1:0]    dec   [NREG];
   logic             haz;
   logic             err_q, err_d;
   logic [3:0]       rf_we_q, rf_we_d;
   logic [4*AW-1:0]  rf_addr_q;
   logic [127:0]     rf_data_q;

   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         inc[r] = '0;
         dec[r] = '0;
      end
      for (int unsigned k = 0; k < 4; k++) begin
         if (issue_we[k])
            inc[issue_dst[AW*k +: AW]] = inc[issue_dst[AW*k +: AW]] + CW'(1);
         if (wb_we[k])
            dec[wb_dst[AW*k +: AW]] = dec[wb_dst[AW*k +: AW]] + CW'(1);
      end
   end

   // Hazard looks only at registered counts: a same-cycle writeback does not release the stall.
   always_comb begin
      logic [AW-1:0] sa;
      logic [AW-1:0] sb;
      haz = 1'b0;
      sa  = '0;
      sb  = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         sa = issue_src[2*AW*k+AW +: AW];
         sb = issue_src[2*AW*k +: AW];
         if (issue_srcv[2*k+1] && (sa != '0) && (cnt_q[sa] != '0)) haz = 1'b1;
         if (issue_srcv[2*k]   && (sb != '0) && (cnt_q[sb] != '0)) haz = 1'b1;
      end
      for (int unsigned r = 1; r < NREG; r++) begin
         if ((CW'(cnt_q[r]) + inc[r]) > CMAX) haz = 1'b1;
      end
   end

   assign hazard_existenceD = issue_valid & haz;
   assign issue_accept      = issue_valid & ~haz;

   always_comb begin
      logic [CW-1:0] incsel;
      logic [CW-1:0] sum;
      err_d    = err_q;
      incsel   = '0;
      sum      = '0;
      cnt_d[0] = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         incsel = issue_accept ? inc[r] : '0;
         sum    = CW'(cnt_q[r]) + incsel - dec[r];
         if (sum[CW-1]) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else if (sum > CMAX) begin
            cnt_d[r] = CMAX[CNT_W-1:0];
         end else begin
            cnt_d[r] = sum[CNT_W-1:0];
         end
      end
      for (int unsigned k = 0; k < 4; k++) begin
         rf_we_d[k] = wb_we[k] & (wb_dst[AW*k +: AW] != '0);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
         err_q     <= 1'b0;
         rf_we_q   <= '0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         err_q     <= err_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= wb_dst;
         rf_data_q <= wb_data;
      end
   end

   assign rf_we      = rf_we_q;
   assign rf_wr_addr = rf_addr_q;
   assign rf_wr_data = rf_data_q;
   assign sb_err     = err_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed bench for writeback_scoreboard: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_writeback_scoreboard;

   logic         clk = 1'b0;
   logic         rstn;
   logic         issue_valid;
   logic [3:0]   issue_we;
   logic [23:0]  issue_dst;
   logic [47:0]  issue_src;
   logic [7:0]   issue_srcv;
   logic         hazard_existenceD;
   logic         issue_accept;
   logic [3:0]   wb_we;
   logic [23:0]  wb_dst;
   logic [127:0] wb_data;
   logic [3:0]   rf_we;
   logic [23:0]  rf_wr_addr;
   logic [127:0] rf_wr_data;
   logic         sb_err;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   writeback_scoreboard #(.NREG(64), .CNT_W(2)) dut (
      .clk(clk), .rstn(rstn),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
      .issue_src(issue_src), .issue_srcv(issue_srcv),
      .hazard_existenceD(hazard_existenceD), .issue_accept(issue_accept),
      .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         iv;
      logic [3:0]   iwe;
      logic [23:0]  idst;
      logic [47:0]  isrc;
      logic [7:0]   isrcv;
      logic [3:0]   wwe;
      logic [23:0]  wdst;
      logic [127:0] wdata;
      logic         ehaz;
      logic [3:0]   erfwe;
      logic         eerr;
   } vec_t;

   vec_t vq[$];

   // Lane arguments are 0-based (0 = lane 1).
   function automatic logic [23:0] D(int unsigned lane, logic [5:0] r);
      logic [23:0] v = '0;
      v[6*lane +: 6] = r;
      return v;
   endfunction
   function automatic logic [47:0] SA(int unsigned lane, logic [5:0] r);
      logic [47:0] v = '0;
      v[12*lane+6 +: 6] = r;
      return v;
   endfunction
   function automatic logic [47:0] SB(int unsigned lane, logic [5:0] r);
      logic [47:0] v = '0;
      v[12*lane +: 6] = r;
      return v;
   endfunction
   function automatic logic [7:0] VA(int unsigned lane);
      logic [7:0] v = '0;
      v[2*lane+1] = 1'b1;
      return v;
   endfunction
   function automatic logic [7:0] VB(int unsigned lane);
      logic [7:0] v = '0;
      v[2*lane] = 1'b1;
      return v;
   endfunction
   function automatic logic [127:0] W(int unsigned lane, logic [31:0] x);
      logic [127:0] v = '0;
      v[32*lane +: 32] = x;
      return v;
   endfunction

   function automatic vec_t mk(logic iv, logic [3:0] iwe, logic [23:0] idst,
                               logic [47:0] isrc, logic [7:0] isrcv,
                               logic [3:0] wwe, logic [23:0] wdst, logic [127:0] wdata,
                               logic ehaz, logic [3:0] erfwe, logic eerr);
      vec_t v;
      v.iv = iv; v.iwe = iwe; v.idst = idst; v.isrc = isrc; v.isrcv = isrcv;
      v.wwe = wwe; v.wdst = wdst; v.wdata = wdata;
      v.ehaz = ehaz; v.erfwe = erfwe; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      else n_pass++;
   endtask

   task automatic drive(input vec_t v);
      issue_valid = v.iv;  issue_we = v.iwe;  issue_dst = v.idst;
      issue_src   = v.isrc; issue_srcv = v.isrcv;
      wb_we = v.wwe; wb_dst = v.wdst; wb_data = v.wdata;
   endtask

   initial begin
      vec_t idle;
      idle = mk(0, '0, '0, '0, '0, '0, '0, '0, 0, '0, 0);
      drive(idle);
      rstn = 1'b0;

      // RAW stall on r5, released by the writeback edge
      vq.push_back(mk(1, 4'b0001, D(0,5), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, '0, '0, SA(1,5), VA(1), '0, '0, '0, 1, 4'b0000, 0));
      vq.push_back(mk(1, '0, '0, SA(1,5), VA(1), '0, '0, '0, 1, 4'b0000, 0));
      vq.push_back(mk(1, '0, '0, SA(1,5), VA(1), 4'b0001, D(0,5), W(0,32'hDEADBEEF), 1, 4'b0001, 0));
      vq.push_back(mk(1, '0, '0, SA(1,5), VA(1), '0, '0, '0, 0, 4'b0000, 0));
      // Register 0
      vq.push_back(mk(1, 4'b0001, D(0,0), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, '0, '0, SA(0,0)|SB(0,0), VA(0)|VB(0), 4'b0100, D(2,0), W(2,32'h12345678), 0, 4'b0000, 0));
      // WAW saturation on r7 and 4-lane r9 overflow
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, '0, '0, '0, 1, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, 4'b0001, D(0,7), W(0,32'h00007777), 1, 4'b0001, 0));
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,7), '0, '0, '0, '0, '0, 1, 4'b0000, 0));
      vq.push_back(mk(1, 4'b1111, D(0,9)|D(1,9)|D(2,9)|D(3,9), '0, '0, '0, '0, '0, 1, 4'b0000, 0));
      // Simultaneous issue+wb on r12, then a double writeback
      vq.push_back(mk(1, 4'b0001, D(0,12), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,12), '0, '0, 4'b0001, D(0,12), W(0,32'h0000C0C0), 0, 4'b0001, 0));
      vq.push_back(mk(1, 4'b0111, D(0,12)|D(1,12)|D(2,12), '0, '0, '0, '0, '0, 1, 4'b0000, 0));
      vq.push_back(mk(1, 4'b0001, D(0,12), '0, '0, '0, '0, '0, 0, 4'b0000, 0));
      vq.push_back(mk(0, '0, '0, '0, '0, 4'b0011, D(0,12)|D(1,12), W(0,32'hAAAA0001)|W(1,32'hBBBB0002), 0, 4'b0011, 0));
      vq.push_back(mk(1, '0, '0, SB(2,12), VB(2), '0, '0, '0, 0, 4'b0000, 0));
      // Underflow on r9: still written, sb_err sticky
      vq.push_back(mk(0, '0, '0, '0, '0, 4'b1000, D(3,9), W(3,32'h99990000), 0, 4'b1000, 1));
      vq.push_back(mk(0, '0, '0, '0, '0, '0, '0, '0, 0, 4'b0000, 1));
      vq.push_back(mk(1, '0, '0, SB(3,9), VB(3), '0, '0, '0, 0, 4'b0000, 1));

      #2;
      chk("reset_rf_we",   rf_we, 0);
      chk("reset_addr",    rf_wr_addr, 0);
      chk("reset_data",    rf_wr_data, 0);
      chk("reset_sb_err",  sb_err, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         #1;
         chk($sformatf("v%0d_hazard", i), hazard_existenceD, vq[i].ehaz);
         chk($sformatf("v%0d_accept", i), issue_accept, vq[i].iv & ~vq[i].ehaz);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rf_we", i), rf_we, vq[i].erfwe);
         chk($sformatf("v%0d_addr", i), rf_wr_addr, vq[i].wdst);
         chk($sformatf("v%0d_data", i), rf_wr_data, vq[i].wdata);
         chk($sformatf("v%0d_sb_err", i), sb_err, vq[i].eerr);
         @(negedge clk);
      end

      // Asynchronous reset with cnt[5]=2 and sb_err=1 pending
      drive(mk(1, 4'b0001, D(0,5), '0, '0, '0, '0, '0, 0, '0, 0));
      @(negedge clk);
      drive(mk(1, 4'b0001, D(0,5), '0, '0, 4'b0001, D(0,3), W(0,32'h0000ABCD), 0, '0, 0));
      #1 chk("rst_pre_accept", issue_accept, 1);
      @(negedge clk);
      drive(mk(1, '0, '0, SA(0,5), VA(0), '0, '0, '0, 0, '0, 0));
      #1;
      chk("rst_pre_hazard5", hazard_existenceD, 1);
      chk("rst_pre_rf_we",   rf_we, 4'b0001);
      rstn = 1'b0;
      #1;
      chk("rst_async_rf_we",  rf_we, 0);
      chk("rst_async_addr",   rf_wr_addr, 0);
      chk("rst_async_data",   rf_wr_data, 0);
      chk("rst_async_sb_err", sb_err, 0);
      chk("rst_async_haz5",   hazard_existenceD, 0);
      drive(mk(1, '0, '0, SA(0,7)|SB(0,5), VA(0)|VB(0), '0, '0, '0, 0, '0, 0));
      #1 chk("rst_async_haz7", hazard_existenceD, 0);
      @(negedge clk);
      rstn = 1'b1;
      drive(mk(0, '0, '0, '0, '0, 4'b0001, D(0,5), W(0,32'h55555555), 0, '0, 0));
      @(posedge clk);
      #1;
      chk("post_rst_wb_rf_we",  rf_we, 4'b0001);
      chk("post_rst_wb_sb_err", sb_err, 1);
      @(negedge clk);
      drive(idle);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
